branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter DATABITWIDTH, default 16, instruction address and data width.
REQ-002 SHALL have parameter INDEXBITS, default 4; the table holds 2^INDEXBITS entries.
REQ-003 SHALL have clk, input, 1: the single clock.
REQ-004 SHALL have clk_en, input, 1: global clock enable.
REQ-005 SHALL have sync_rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have StallEnable, input, 1: pipeline stall; blocks speculation start.
REQ-007 SHALL have BranchFetched, input, 1: current instruction is a conditional branch.
REQ-008 SHALL have FetchPC, input, DATABITWIDTH: address of the current instruction.
REQ-009 SHALL have EndSpeculationPulse, input, 1: the outstanding branch resolves this cycle.
REQ-010 SHALL have BranchTaken, input, 1: resolved direction; valid with EndSpeculationPulse.
REQ-011 SHALL have MispredictedSpeculationPulse, input, 1: resolution disagreed with the prediction.
REQ-012 SHALL have ActualDestination, input, DATABITWIDTH: resolved target; valid with EndSpeculationPulse.
REQ-013 SHALL have Speculating, output, 1: a speculation is outstanding.
REQ-014 SHALL have BeginSpeculationPulse, output, 1: start a speculation this cycle.
REQ-015 SHALL have PredictingTrue, output, 1: the branch is predicted taken.
REQ-016 SHALL have RelativeSpeculation, output, 1: constant 0; the table supplies absolute targets.
REQ-017 SHALL have SpeculativeDestination, output, DATABITWIDTH: the predicted target.
REQ-018 SHALL have PredictionCount and MispredictCount, outputs, 16 each: performance counters (REQ-035).

Function
REQ-019 SHALL use this entry format: valid bit, tag FetchPC[DATABITWIDTH-1:INDEXBITS], DATABITWIDTH target, 2-bit saturating counter.
REQ-020 SHALL look up the table combinationally, indexed by FetchPC[INDEXBITS-1:0].
- Hit = valid && tag match.
REQ-021 SHALL use a two-state FSM, IDLE and SPEC; Speculating = (state==SPEC).
REQ-022 SHALL drive BeginSpeculationPulse = BranchFetched && state==IDLE && ~sync_rst, combinationally.
- Asserts on a hit or a miss; a miss predicts not-taken.
REQ-023 SHALL drive PredictingTrue = BeginSpeculationPulse && Hit && counter[1].
REQ-024 SHALL drive SpeculativeDestination = entry target when PredictingTrue, else 0.
REQ-025 SHALL, on IDLE->SPEC, capture index, tag, Hit, counter and PredictingTrue into resolve registers.
- Transition condition: clk_en && ~StallEnable && BeginSpeculationPulse.
- BeginSpeculationPulse may assert while stalled; the state does not advance until the stall clears.
REQ-026 SHALL hold BeginSpeculationPulse low in SPEC and ignore BranchFetched there (one outstanding speculation).
REQ-027 SHALL go SPEC->IDLE on clk_en && EndSpeculationPulse and update the captured entry in that same edge.
- A resolve together with a new fetched branch gives no begin that cycle; the begin follows one cycle later.
REQ-028 SHALL apply these updates on a captured hit:
- counter saturating +1 if BranchTaken, else saturating -1 (limits 2'b00 and 2'b11);
- target <= ActualDestination if BranchTaken.
REQ-029 SHALL apply these updates on a captured miss:
- BranchTaken: allocate the entry (valid=1, captured tag, target=ActualDestination, counter=2'b10), overwriting any occupant;
- not taken: no table write.
REQ-030 SHALL ignore EndSpeculationPulse in IDLE: no update and no state change.
REQ-031 SHALL perform no state or table change while clk_en=0.

Reset
REQ-032 SHALL, on sync_rst, clear every valid bit, set every counter to 2'b01, set state to IDLE and zero the resolve registers.
REQ-033 SHALL, on sync_rst during SPEC, abandon the speculation with no table update.
REQ-034 SHALL hold these reset values:
- Speculating, BeginSpeculationPulse, PredictingTrue, SpeculativeDestination and RelativeSpeculation all 0;
- counters 0 when compiled in.

Configuration
REQ-035 SHALL compile the performance counters in or out with macro BRANCH_PREDICTOR_PERF_COUNTERS_EN.
- Defined: PredictionCount +1 on each IDLE->SPEC; MispredictCount +1 on clk_en && EndSpeculationPulse && MispredictedSpeculationPulse in SPEC.
- Defined: both 16-bit saturating at 16'hFFFF; both cleared by sync_rst.
- Undefined: both outputs are constant 0 and no counter registers exist.

Verification
REQ-036 SHALL cover a cold miss: reset, BranchFetched FetchPC=0x0013.
- Required: BeginSpeculationPulse=1, PredictingTrue=0, Speculating=1 next cycle.
REQ-037 SHALL cover allocate then hit: resolve the REQ-036 branch BranchTaken=1, ActualDestination=0x0040; refetch 0x0013.
- Required: PredictingTrue=1, SpeculativeDestination=0x0040.
REQ-038 SHALL cover counter saturation and decay: resolve the 0x0013 branch taken twice, then not-taken twice.
- Required: counter 2'b10->2'b11->2'b11 (saturated), then 2'b10->2'b01.
- Required: the next fetch of 0x0013 gives PredictingTrue=0.
REQ-039 SHALL cover an alias conflict: 0x0023 (same index, different tag) fetched with 0x0013 allocated.
- Required: miss, PredictingTrue=0; on a taken resolve to 0x0080 the entry is replaced and 0x0013 then misses.
REQ-040 SHALL cover stall and single outstanding:
- StallEnable=1 with BranchFetched: state stays IDLE;
- in SPEC, BranchFetched gives no pulse;
- a resolve in the same cycle as a new branch gives a pulse the next cycle.
REQ-041 SHALL cover reset mid-speculation and the counters:
- sync_rst in SPEC: IDLE, no table write;
- with the macro defined, 3 speculations with 1 mispredict read 3/1; with it undefined, both outputs read 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target predictor with 2-bit counters and one outstanding speculation.
// Optional perf counters: define BRANCH_PREDICTOR_PERF_COUNTERS_EN.
module branch_predictor #(
  parameter int DATABITWIDTH = 16,
  parameter int INDEXBITS    = 4
) (
  input  logic                    clk,
  input  logic                    clk_en,
  input  logic                    sync_rst,
  input  logic                    StallEnable,
  input  logic                    BranchFetched,
  input  logic [DATABITWIDTH-1:0] FetchPC,
  input  logic                    EndSpeculationPulse,
  input  logic                    BranchTaken,
  input  logic                    MispredictedSpeculationPulse,
  input  logic [DATABITWIDTH-1:0] ActualDestination,
  output logic                    Speculating,
  output logic                    BeginSpeculationPulse,
  output logic                    PredictingTrue,
  output logic                    RelativeSpeculation,
  output logic [DATABITWIDTH-1:0] SpeculativeDestination,
  output logic [15:0]             PredictionCount,
  output logic [15:0]             MispredictCount
);

  localparam int TW = DATABITWIDTH - INDEXBITS;
  localparam int NE = 1 << INDEXBITS;

  localparam logic IDLE = 1'b0;
  localparam logic SPEC = 1'b1;

  logic                    valid_q [NE];
  logic [TW-1:0]           tag_q   [NE];
  logic [DATABITWIDTH-1:0] tgt_q   [NE];
  logic [1:0]              cnt_q   [NE];

  logic                 state_q;
  logic [INDEXBITS-1:0] ridx_q;
  logic [TW-1:0]        rtag_q;
  logic                 rhit_q;
  logic [1:0]           rcnt_q;
  logic                 rpred_q;

  logic [INDEXBITS-1:0] idx;
  logic [TW-1:0]        tag;
  logic                 hit;
  logic                 spec_start;
  logic                 spec_end;
  logic [1:0]           cnt_d;

  assign idx = FetchPC[INDEXBITS-1:0];
  assign tag = FetchPC[DATABITWIDTH-1:INDEXBITS];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  assign Speculating           = (state_q == SPEC);
  assign BeginSpeculationPulse = BranchFetched && (state_q == IDLE) && ~sync_rst;
  assign PredictingTrue        = BeginSpeculationPulse && hit && cnt_q[idx][1];
  assign RelativeSpeculation   = 1'b0;
  assign SpeculativeDestination =
    PredictingTrue ? tgt_q[idx] : '0;

  assign spec_start = clk_en && ~StallEnable && BeginSpeculationPulse;
  assign spec_end   = clk_en && EndSpeculationPulse && (state_q == SPEC);

  always_comb begin
    cnt_d = rcnt_q;
    if (BranchTaken) begin
      if (rcnt_q != 2'b11) cnt_d = rcnt_q + 2'b01;
    end else begin
      if (rcnt_q != 2'b00) cnt_d = rcnt_q - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q <= IDLE;
      ridx_q  <= '0;
      rtag_q  <= '0;
      rhit_q  <= 1'b0;
      rcnt_q  <= '0;
      rpred_q <= 1'b0;
      for (int i = 0; i < NE; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= 2'b01;
      end
    end else if (spec_start) begin
      state_q <= SPEC;
      ridx_q  <= idx;
      rtag_q  <= tag;
      rhit_q  <= hit;
      rcnt_q  <= cnt_q[idx];
      rpred_q <= PredictingTrue;
    end else if (spec_end) begin
      state_q <= IDLE;
      if (rhit_q) begin
        cnt_q[ridx_q] <= cnt_d;
        if (BranchTaken) tgt_q[ridx_q] <= ActualDestination;
      end else if (BranchTaken) begin
        valid_q[ridx_q] <= 1'b1;
        tag_q[ridx_q]   <= rtag_q;
        tgt_q[ridx_q]   <= ActualDestination;
        cnt_q[ridx_q]   <= 2'b10;
      end
    end
  end

  // Captured prediction is kept for debug visibility only.
  logic unused_rpred;
  assign unused_rpred = rpred_q;

`ifdef BRANCH_PREDICTOR_PERF_COUNTERS_EN
  logic [15:0] pcnt_q;
  logic [15:0] mcnt_q;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      pcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      if (spec_start && pcnt_q != 16'hFFFF)
        pcnt_q <= pcnt_q + 16'd1;
      if (spec_end && MispredictedSpeculationPulse &&
          mcnt_q != 16'hFFFF)
        mcnt_q <= mcnt_q + 16'd1;
    end
  end

  assign PredictionCount = pcnt_q;
  assign MispredictCount = mcnt_q;
`else
  assign PredictionCount = '0;
  assign MispredictCount = '0;

  logic unused_mispred;
  assign unused_mispred = MispredictedSpeculationPulse;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: vector table with scoreboard plus
// hand sequences for stall, clock enable, reset and counters.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        clk_en;
  logic        sync_rst;
  logic        StallEnable;
  logic        BranchFetched;
  logic [15:0] FetchPC;
  logic        EndSpeculationPulse;
  logic        BranchTaken;
  logic        MispredictedSpeculationPulse;
  logic [15:0] ActualDestination;
  logic        Speculating;
  logic        BeginSpeculationPulse;
  logic        PredictingTrue;
  logic        RelativeSpeculation;
  logic [15:0] SpeculativeDestination;
  logic [15:0] PredictionCount;
  logic [15:0] MispredictCount;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_predictor #(.DATABITWIDTH(16), .INDEXBITS(4)) dut (
    .clk(clk),
    .clk_en(clk_en),
    .sync_rst(sync_rst),
    .StallEnable(StallEnable),
    .BranchFetched(BranchFetched),
    .FetchPC(FetchPC),
    .EndSpeculationPulse(EndSpeculationPulse),
    .BranchTaken(BranchTaken),
    .MispredictedSpeculationPulse(MispredictedSpeculationPulse),
    .ActualDestination(ActualDestination),
    .Speculating(Speculating),
    .BeginSpeculationPulse(BeginSpeculationPulse),
    .PredictingTrue(PredictingTrue),
    .RelativeSpeculation(RelativeSpeculation),
    .SpeculativeDestination(SpeculativeDestination),
    .PredictionCount(PredictionCount),
    .MispredictCount(MispredictCount)
  );

  typedef struct {
    logic [15:0] pc;
    logic        tk;
    logic [15:0] ad;
    logic        pred;
    logic [15:0] dest;
  } vec_t;

  typedef struct {
    logic        beg;
    logic        pred;
    logic [15:0] dest;
  } exp_t;

  vec_t vt[14];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    sync_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sync_rst = 1'b0;
  endtask

  task automatic spec(input string nm, input logic [15:0] pc,
                      input logic tk, input logic [15:0] ad,
                      input logic pred, input logic [15:0] dest);
    exp_t e;
    @(negedge clk);
    BranchFetched = 1'b1;
    FetchPC = pc;
    e.beg = 1'b1;
    e.pred = pred;
    e.dest = dest;
    sb.push_back(e);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_sb: got empty expected entry", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, "_beg"}, {31'd0, BeginSpeculationPulse}, {31'd0, e.beg});
      chk({nm, "_pred"}, {31'd0, PredictingTrue}, {31'd0, e.pred});
      chk({nm, "_dest"}, {16'd0, SpeculativeDestination},
          {16'd0, e.dest});
    end
    @(negedge clk);
    BranchFetched = 1'b0;
    EndSpeculationPulse = 1'b1;
    BranchTaken = tk;
    ActualDestination = ad;
    MispredictedSpeculationPulse = (pred != tk);
    #1;
    chk({nm, "_spec"}, {31'd0, Speculating}, 32'd1);
    @(negedge clk);
    EndSpeculationPulse = 1'b0;
    MispredictedSpeculationPulse = 1'b0;
    #1;
    chk({nm, "_idle"}, {31'd0, Speculating}, 32'd0);
  endtask

  initial begin
    vt[0]  = '{16'h0013, 1'b1, 16'h0040, 1'b0, 16'h0000};
    vt[1]  = '{16'h0013, 1'b1, 16'h0040, 1'b1, 16'h0040};
    vt[2]  = '{16'h0013, 1'b1, 16'h0040, 1'b1, 16'h0040};
    vt[3]  = '{16'h0013, 1'b0, 16'h0000, 1'b1, 16'h0040};
    vt[4]  = '{16'h0013, 1'b0, 16'h0000, 1'b1, 16'h0040};
    vt[5]  = '{16'h0013, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[6]  = '{16'h0013, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[7]  = '{16'h0023, 1'b1, 16'h0080, 1'b0, 16'h0000};
    vt[8]  = '{16'h0013, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[9]  = '{16'h0023, 1'b1, 16'h0080, 1'b1, 16'h0080};
    vt[10] = '{16'h0005, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[11] = '{16'h0005, 1'b1, 16'h1234, 1'b0, 16'h0000};
    vt[12] = '{16'h0005, 1'b1, 16'h2222, 1'b1, 16'h1234};
    vt[13] = '{16'h0005, 1'b1, 16'h2222, 1'b1, 16'h2222};

    clk_en = 1'b1;
    sync_rst = 1'b1;
    StallEnable = 1'b0;
    BranchFetched = 1'b1;
    FetchPC = 16'h0013;
    EndSpeculationPulse = 1'b0;
    BranchTaken = 1'b0;
    MispredictedSpeculationPulse = 1'b0;
    ActualDestination = 16'h0000;

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_beg", {31'd0, BeginSpeculationPulse}, 32'd0);
    chk("rst_spec", {31'd0, Speculating}, 32'd0);
    chk("rst_pred", {31'd0, PredictingTrue}, 32'd0);
    chk("rst_dest", {16'd0, SpeculativeDestination}, 32'd0);
    chk("rst_rel", {31'd0, RelativeSpeculation}, 32'd0);
    chk("rst_pcnt", {16'd0, PredictionCount}, 32'd0);
    chk("rst_mcnt", {16'd0, MispredictCount}, 32'd0);
    sync_rst = 1'b0;
    BranchFetched = 1'b0;

    for (int i = 0; i < 14; i++)
      spec($sformatf("vec%0d", i), vt[i].pc, vt[i].tk, vt[i].ad,
           vt[i].pred, vt[i].dest);

    // Stall holds IDLE, single outstanding, resolve-then-begin.
    do_reset();
    @(negedge clk);
    StallEnable = 1'b1;
    BranchFetched = 1'b1;
    FetchPC = 16'h0013;
    #1;
    chk("stall_beg", {31'd0, BeginSpeculationPulse}, 32'd1);
    chk("stall_pred", {31'd0, PredictingTrue}, 32'd0);
    @(negedge clk);
    #1;
    chk("stall_idle", {31'd0, Speculating}, 32'd0);
    StallEnable = 1'b0;
    @(negedge clk);
    #1;
    chk("unstall_spec", {31'd0, Speculating}, 32'd1);
    chk("spec_nobeg", {31'd0, BeginSpeculationPulse}, 32'd0);
    EndSpeculationPulse = 1'b1;
    BranchTaken = 1'b1;
    ActualDestination = 16'h0040;
    #1;
    chk("resolve_nobeg", {31'd0, BeginSpeculationPulse}, 32'd0);
    @(negedge clk);
    EndSpeculationPulse = 1'b0;
    BranchTaken = 1'b0;
    #1;
    chk("after_idle", {31'd0, Speculating}, 32'd0);
    chk("after_beg", {31'd0, BeginSpeculationPulse}, 32'd1);
    chk("after_pred", {31'd0, PredictingTrue}, 32'd1);
    chk("after_dest", {16'd0, SpeculativeDestination}, 32'h0040);
    @(negedge clk);
    BranchFetched = 1'b0;
    #1;
    chk("respec", {31'd0, Speculating}, 32'd1);

    // Reset in SPEC abandons the speculation and clears the table.
    sync_rst = 1'b1;
    EndSpeculationPulse = 1'b1;
    BranchTaken = 1'b1;
    ActualDestination = 16'h0099;
    @(negedge clk);
    sync_rst = 1'b0;
    EndSpeculationPulse = 1'b0;
    BranchTaken = 1'b0;
    #1;
    chk("midrst_idle", {31'd0, Speculating}, 32'd0);
    spec("midrst_miss", 16'h0013, 1'b0, 16'h0000, 1'b0, 16'h0000);

    // Clock enable low freezes state in both directions.
    @(negedge clk);
    clk_en = 1'b0;
    BranchFetched = 1'b1;
    FetchPC = 16'h0033;
    #1;
    chk("cen_beg", {31'd0, BeginSpeculationPulse}, 32'd1);
    @(negedge clk);
    #1;
    chk("cen_idle", {31'd0, Speculating}, 32'd0);
    clk_en = 1'b1;
    @(negedge clk);
    BranchFetched = 1'b0;
    clk_en = 1'b0;
    EndSpeculationPulse = 1'b1;
    @(negedge clk);
    #1;
    chk("cen_hold_spec", {31'd0, Speculating}, 32'd1);
    clk_en = 1'b1;
    @(negedge clk);
    EndSpeculationPulse = 1'b0;
    #1;
    chk("cen_end_idle", {31'd0, Speculating}, 32'd0);

    // Performance counters; stray resolve in IDLE must not count.
    do_reset();
    @(negedge clk);
    EndSpeculationPulse = 1'b1;
    MispredictedSpeculationPulse = 1'b1;
    BranchTaken = 1'b1;
    ActualDestination = 16'h0777;
    @(negedge clk);
    EndSpeculationPulse = 1'b0;
    MispredictedSpeculationPulse = 1'b0;
    BranchTaken = 1'b0;
    #1;
    chk("idle_end_nostate", {31'd0, Speculating}, 32'd0);
    spec("pc0", 16'h0100, 1'b1, 16'h0200, 1'b0, 16'h0000);
    spec("pc1", 16'h0100, 1'b1, 16'h0200, 1'b1, 16'h0200);
    spec("pc2", 16'h0101, 1'b0, 16'h0000, 1'b0, 16'h0000);
`ifdef BRANCH_PREDICTOR_PERF_COUNTERS_EN
    chk("pcnt", {16'd0, PredictionCount}, 32'd3);
    chk("mcnt", {16'd0, MispredictCount}, 32'd1);
`else
    chk("pcnt", {16'd0, PredictionCount}, 32'd0);
    chk("mcnt", {16'd0, MispredictCount}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
